fft_out_reorder_32: RTL and testbench

- Output stage of the 32-point SDF FFT pipeline; sits after the last butterfly/delay-line stage.
- The pipeline emits each 32-sample frame in bit-reversed index order. This block buffers one frame and re-emits it in natural order (index 0..31) as a continuous 32-cycle burst with out_valid.
- Ping-pong buffer: two 32-entry banks. One bank is written while the other is read, so back-to-back frames stream without stall.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_reorder_bank.sv | 27 ++
 rtl/fft_out_reorder_32.sv | 155 +++++++++++++++
 tb/tb_fft_out_reorder_32.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the 32-point SDF FFT pipeline.
//   DW     - real/imag sample width (signed)
//   N      - points per frame (power of 2)
//   LOG2N  - index width, log2(N)
//   bitrev5 - LOG2N-bit index bit reversal
package fft_pkg;
  localparam int DW    = 24;
  localparam int N     = 32;
  localparam int LOG2N = 5;

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one ping-pong bank, DEPTH x W register array.
//   clk      - clock, rising edge
//   wr_en    - write wr_data at wr_addr
//   rd_en    - capture mem[rd_addr] into rd_data (one-cycle read latency)
// Contents and read register are intentionally not reset.
import fft_pkg::*;

module fft_reorder_bank #(
  parameter int W     = 2*DW,
  parameter int DEPTH = N,
  parameter int AW    = LOG2N
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fft_out_reorder_32.sv
// fft_out_reorder_32: bit-reversed -> natural order output stage of the
// 32-point SDF FFT. Ping-pong banks: one frame is written while the previous
// one is re-emitted as a contiguous 32-cycle burst.
//   clk, reset      - clock; asynchronous active-high reset
//   in_valid, din_* - input sample, frame arrives in bit-reversed order
//   out_valid       - dout_r/dout_i/out_idx valid (registered)
//   out_idx         - natural index of current output sample
//   out_last        - (FFT_REORDER_LAST_EN only) high with out_idx == N-1
//   frame_err       - sticky: a frame completed before the burst finished
// Optional feature macro: FFT_REORDER_LAST_EN.
import fft_pkg::*;

module fft_out_reorder_32 #(
  parameter int DW    = fft_pkg::DW,
  parameter int N     = fft_pkg::N,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    din_r,
  input  logic signed [DW-1:0]    din_i,
  output logic                    out_valid,
  output logic signed [DW-1:0]    dout_r,
  output logic signed [DW-1:0]    dout_i,
  output logic [LOG2N-1:0]        out_idx,
`ifdef FFT_REORDER_LAST_EN
  output logic                    out_last,
`endif
  output logic                    frame_err
);
  typedef enum logic {S_IDLE, S_READ} state_t;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } smp_t;

  // issue -> bank read register -> output register
  localparam int RD_STAGES = 2;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N-1);

  logic [LOG2N-1:0]   wr_cnt;
  logic               wr_bank;
  logic               frame_done;
  state_t             state, state_nxt;
  logic [LOG2N-1:0]   rd_cnt, rd_cnt_nxt;
  logic               rd_bank, rd_bank_nxt, rd_bank_d;
  logic               err_set;
  logic               issue;
  logic [RD_STAGES:1] vld_q;
  logic [RD_STAGES:0] vld_pipe;
  logic [LOG2N-1:0]   idx_d;
  smp_t               wr_smp;
  smp_t [1:0]         rd_smp;

  // The 32nd write of a frame; drives both bank swap and read start.
  assign frame_done = in_valid && (wr_cnt == LAST);
  assign wr_smp     = {din_r, din_i};
  assign issue      = (state == S_READ);
  assign vld_pipe   = {vld_q, issue};
  assign out_valid  = vld_pipe[RD_STAGES];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.W(2*DW), .DEPTH(N), .AW(LOG2N)) u_bank (
      .clk     (clk),
      .wr_en   (in_valid && (wr_bank == 1'(b))),
      .wr_addr (bitrev5(wr_cnt)),
      .wr_data (wr_smp),
      .rd_en   (issue && (rd_bank == 1'(b))),
      .rd_addr (rd_cnt),
      .rd_data (rd_smp[b])
    );
  end

  // Write side: never stalls, gaps just hold the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else begin
      if (in_valid)   wr_cnt  <= wr_cnt + 1'b1;
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  // Read FSM next state. A completion on the final issue is a seamless
  // handoff; a completion any earlier aborts the burst and flags overrun.
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    err_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_done) begin
          state_nxt   = S_READ;
          rd_cnt_nxt  = '0;
          rd_bank_nxt = wr_bank;
        end
      end
      S_READ: begin
        rd_cnt_nxt = rd_cnt + 1'b1;
        if (frame_done) begin
          rd_cnt_nxt  = '0;
          rd_bank_nxt = wr_bank;
          err_set     = (rd_cnt != LAST);
        end else if (rd_cnt == LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_bank_d <= 1'b0;
      idx_d     <= '0;
      vld_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_cnt    <= rd_cnt_nxt;
      rd_bank   <= rd_bank_nxt;
      rd_bank_d <= rd_bank;
      idx_d     <= rd_cnt;
      vld_q     <= vld_pipe[RD_STAGES-1:0];
      if (err_set) frame_err <= 1'b1;
    end
  end

  // Output register: rd_bank_d selects the bank whose read was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_r  <= '0;
      dout_i  <= '0;
      out_idx <= '0;
`ifdef FFT_REORDER_LAST_EN
      out_last <= 1'b0;
`endif
    end else begin
      if (vld_pipe[1]) begin
        dout_r  <= rd_smp[rd_bank_d].re;
        dout_i  <= rd_smp[rd_bank_d].im;
        out_idx <= idx_d;
      end
`ifdef FFT_REORDER_LAST_EN
      out_last <= vld_pipe[1] && (idx_d == LAST);
`endif
    end
  end
endmodule

// File: tb/tb_fft_out_reorder_32.sv
// tb_fft_out_reorder_32: scoreboard bench for fft_out_reorder_32.
// Stimulus pushes expected output samples and status checks into queues;
// a negedge monitor pops and compares. Honors FFT_REORDER_LAST_EN.
module tb_fft_out_reorder_32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic signed [23:0] din_r = '0, din_i = '0;
  logic signed [23:0] dout_r, dout_i;
  logic out_valid, frame_err;
  logic [4:0] out_idx;
`ifdef FFT_REORDER_LAST_EN
  logic out_last;
`endif

  always #5 clk = ~clk;

  fft_out_reorder_32 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i),
    .out_idx   (out_idx),
`ifdef FFT_REORDER_LAST_EN
    .out_last  (out_last),
`endif
    .frame_err (frame_err)
  );

  typedef struct {
    logic signed [23:0] re;
    logic signed [23:0] im;
    logic [4:0]         idx;
    bit                 cont;  // must directly follow another valid cycle
  } exp_t;
  typedef enum int {C_VALID, C_ERR, C_RST, C_DRAIN} ck_t;
  typedef struct {
    ck_t   kind;
    int    expv;
    string name;
  } chk_t;

  exp_t q[$];
  chk_t cq[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit prev_vld = 1'b0;

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < 5; i++) if ((k & (1 << i)) != 0) r |= 1 << (4 - i);
    return r;
  endfunction

  // Monitor: status checks first, then scoreboard pop on out_valid.
  always @(negedge clk) begin
    exp_t e;
    chk_t c;
    bit bad;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      n_cmp++;
      bad = 1'b0;
      case (c.kind)
        C_VALID: bad = (out_valid !== c.expv[0]);
        C_ERR:   bad = (frame_err !== c.expv[0]);
        C_RST: begin
          bad = (out_valid !== 1'b0) || (frame_err !== 1'b0) || (out_idx !== 5'd0) ||
                (dout_r !== 24'sd0) || (dout_i !== 24'sd0);
`ifdef FFT_REORDER_LAST_EN
          bad = bad || (out_last !== 1'b0);
`endif
        end
        default: bad = (q.size() != c.expv);
      endcase
      if (bad) begin
        n_bad++;
        $display("FAIL %s: got valid=%b err=%b idx=%0d r=%0d i=%0d qsize=%0d, required %0d",
                 c.name, out_valid, frame_err, out_idx, dout_r, dout_i, q.size(), c.expv);
      end
    end
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got idx=%0d r=%0d i=%0d, required no output",
                 out_idx, dout_r, dout_i);
      end else begin
        e = q.pop_front();
        bad = (dout_r !== e.re) || (dout_i !== e.im) || (out_idx !== e.idx) ||
              (e.cont && !prev_vld);
`ifdef FFT_REORDER_LAST_EN
        bad = bad || (out_last !== (e.idx == 5'd31));
`endif
        if (bad) begin
          n_bad++;
          $display("FAIL sample: got idx=%0d r=%0d i=%0d prev_vld=%b, required idx=%0d r=%0d i=%0d cont=%b",
                   out_idx, dout_r, dout_i, prev_vld, e.idx, e.re, e.im, e.cont);
        end
      end
    end
`ifdef FFT_REORDER_LAST_EN
    else begin
      n_cmp++;
      if (out_last !== 1'b0) begin
        n_bad++;
        $display("FAIL last_idle: got out_last=%b, required 0", out_last);
      end
    end
`endif
    prev_vld = (out_valid === 1'b1);
  end

  task automatic push_chk(input ck_t k, input int v, input string n);
    chk_t c;
    c.kind = k;
    c.expv = v;
    c.name = n;
    cq.push_back(c);
  endtask

  task automatic drive(input bit v, input int r, input int i);
    @(posedge clk);
    #1;
    in_valid = v;
    din_r    = r[23:0];
    din_i    = i[23:0];
  endtask

  task automatic idle();
    drive(1'b0, 0, 0);
  endtask

  // Natural index j carries re = ra + rb*j, im = ia + ib*j.
  task automatic expect_frame(input int ra, input int rb, input int ia, input int ib,
                              input bit first_cont, input int n);
    exp_t e;
    int v;
    for (int j = 0; j < n; j++) begin
      v = ra + rb * j;  e.re = v[23:0];
      v = ia + ib * j;  e.im = v[23:0];
      v = j;            e.idx = v[4:0];
      e.cont = (j == 0) ? first_cont : 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic send_frame(input int ra, input int rb, input int ia, input int ib,
                            input bit gaps);
    int k = 0;
    int c = 0;
    int j;
    while (k < 32) begin
      if (gaps && (c % 3 == 2)) idle();
      else begin
        j = brev(k);
        drive(1'b1, ra + rb * j, ia + ib * j);
        k++;
      end
      c++;
    end
  endtask

  task automatic wait_drain(input string n);
    for (int t = 0; t < 200; t++) begin
      if (q.size() == 0) break;
      idle();
    end
    push_chk(C_DRAIN, 0, n);
    idle();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1;
    push_chk(C_RST, 0, "reset_state");
    @(posedge clk);
    #1 reset = 1'b0;
    idle();

    // 1: continuous frame, plus two-edge latency
    expect_frame(0, 16, 0, -1, 1'b0, 32);
    send_frame(0, 16, 0, -1, 1'b0);
    idle(); push_chk(C_VALID, 0, "lat_edge0");
    idle(); push_chk(C_VALID, 0, "lat_edge1");
    idle(); push_chk(C_VALID, 1, "lat_edge2");
    wait_drain("drain_t1");

    // 2: same frame with a gap every third cycle
    expect_frame(0, 16, 0, -1, 1'b0, 32);
    send_frame(0, 16, 0, -1, 1'b1);
    wait_drain("drain_t2");
    push_chk(C_ERR, 0, "err_after_gaps");

    // 3: four back-to-back frames, no bubble between bursts
    for (int f = 0; f < 4; f++) expect_frame(f * 1000, 1, -f * 1000, -1, (f > 0), 32);
    for (int f = 0; f < 4; f++) send_frame(f * 1000, 1, -f * 1000, -1, 1'b0);
    wait_drain("drain_t3");

    // 4: reset after 17 inputs discards the partial frame
    for (int k = 0; k < 17; k++) drive(1'b1, 9999, -9999);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    push_chk(C_RST, 0, "reset_mid_frame");
    @(posedge clk);
    #1 reset = 1'b0;
    idle(); idle();
    push_chk(C_VALID, 0, "no_out_after_partial");
    expect_frame(5000, 1, 0, -7, 1'b0, 32);
    send_frame(5000, 1, 0, -7, 1'b0);
    wait_drain("drain_t4");
    push_chk(C_ERR, 0, "err_after_reset");

    // 5: completion forced mid-burst; burst restarts on the other bank,
    //    which still holds the frame from step 4.
    expect_frame(2000, 1, 0, 1, 1'b0, 12);
    send_frame(2000, 1, 0, 1, 1'b0);
    found = 1'b0;
    for (int t = 0; t < 100; t++) begin
      idle();
      if (out_valid === 1'b1 && out_idx == 5'd9) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      force dut.frame_done = 1'b1;
      expect_frame(5000, 1, 0, -7, 1'b1, 32);
      idle();
      release dut.frame_done;
    end
    idle();
    push_chk(C_ERR, 1, "err_overrun");
    wait_drain("drain_t5");
    push_chk(C_ERR, 1, "err_sticky");
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
